// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants and types for the VGA receive-side timing monitor.
//   The constants describe 640x480@60 in pixel ticks (horizontal) and lines
//   (vertical). The derived values give the start and end of the active
//   window. The FSM state enum is shared by the monitor.
package vga_timing_pkg;

    localparam int H_TOTAL  = 800;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;

    localparam int V_TOTAL  = 525;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_ACTIVE = 480;

    localparam int H_ACT_START = H_SYNC + H_BP;           // 144
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;  // 784, exclusive
    localparam int V_ACT_START = V_SYNC + V_BP;           // 35
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;  // 515, exclusive

    localparam int LOCK_FRAMES_DEFAULT = 2;

    // Position counters are 10 bits and saturate at all-ones.
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_timing_monitor_sync_edge_detect.sv
// sync_edge_detect
//   Holds the previous pixel-tick sample of one sync line and reports its
//   falling and rising edges. The edge pulses are combinational: they are
//   valid only in the clk cycle that carries pix_en. The sample resets to 1,
//   so a line that is already low when reset is released produces one
//   falling edge on the first pixel tick. It does not produce a rising edge.
//
//   Ports:
//     clk, rst_n  100 MHz clock, asynchronous active-low reset
//     pix_en      pixel-tick strobe; the sample updates only when it is high
//     level       sync input sampled on each pixel tick
//     fall        previous sample 1 and current input 0 (only on pix_en)
//     rise        previous sample 0 and current input 1 (only on pix_en)
module sync_edge_detect
    import vga_timing_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pix_en,
    input  logic level,
    output logic fall,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else if (pix_en) begin
            prev <= level;
        end
    end

    assign fall = pix_en &  prev & ~level;
    assign rise = pix_en & ~prev &  level;

endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
//   Receive-side VGA timing checker. The design runs in the 100 MHz clk domain
//   and does its work on pixel ticks marked by pix_en. From hsync and vsync it
//   rebuilds the horizontal counter (hc) and the vertical counter (vc). It
//   checks line and frame timing. After LOCK_FRAMES clean frames it locks and
//   drives x, y and active for downstream pixel consumers.
//
//   Optional feature: define VGA_MON_BRIGHT_CHECK_EN to compare the incoming
//   bright flag with the monitor's own active window while locked. When the
//   macro is undefined, bright is ignored and err_bright is tied to 0.
//
//   Ports:
//     clk, rst_n           100 MHz clock, asynchronous active-low reset
//     pix_en               one-clk pixel-tick strobe
//     hsync, vsync         active-low sync inputs
//     bright               incoming active-video flag
//     x, y                 active column/line, 0 outside the active window
//     active               locked and inside the active window
//     locked               timing lock
//     frame_start          one-clk pulse on each vsync fall
//     err_h, err_v         one-clk line / frame timing violation pulses
//     err_bright           sticky bright mismatch
//
//   Timing parameters default to 640x480@60. They can be reduced for short
//   simulations.
module vga_timing_monitor
    import vga_timing_pkg::*;
#(
    parameter int LINE_TICKS  = H_TOTAL,
    parameter int HSYNC_TICKS = H_SYNC,
    parameter int HACT_START  = H_ACT_START,
    parameter int HACT_TICKS  = H_ACTIVE,
    parameter int FRAME_LINES = V_TOTAL,
    parameter int VSYNC_LINES = V_SYNC,
    parameter int VACT_START  = V_ACT_START,
    parameter int VACT_LINES  = V_ACTIVE,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       bright,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       locked,
    output logic       frame_start,
    output logic       err_h,
    output logic       err_v,
    output logic       err_bright
);

    logic hs_fall, hs_rise, vs_fall, vs_rise;

    sync_edge_detect u_hs_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en),
        .level  (hsync),
        .fall   (hs_fall),
        .rise   (hs_rise)
    );

    sync_edge_detect u_vs_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en),
        .level  (vsync),
        .fall   (vs_fall),
        .rise   (vs_rise)
    );

    logic [CNT_W-1:0] hc, vc, hc_next, vc_next;
    logic [CNT_W:0]   hc_inc, vc_inc;
    logic [3:0]       good_cnt, good_next;
    logic             clean, clean_next;
    mon_state_t       state, state_next;
    logic             err_h_now, err_v_now, err_any;
    logic             locked_next, active_next, in_window;
    logic [9:0]       x_next, y_next;

    // One-bit-wider increments, so that "count + 1" can be compared with the
    // nominal totals before saturation.
    assign hc_inc = {1'b0, hc} + (CNT_W+1)'(1);
    assign vc_inc = {1'b0, vc} + (CNT_W+1)'(1);

    always_comb begin
        hc_next   = hc;
        vc_next   = vc;
        err_h_now = 1'b0;
        err_v_now = 1'b0;
        if (pix_en) begin
            if (hs_fall) begin
                hc_next = '0;
                // The line length is unknown until the first frame is
                // acquired, so this check is skipped in SEARCH.
                if (state != SEARCH && hc_inc != (CNT_W+1)'(LINE_TICKS)) begin
                    err_h_now = 1'b1;
                end
            end else begin
                hc_next = sat_inc(hc);
                // hc passes LINE_TICKS only once, so the timeout fires once per line.
                if (hc_inc == (CNT_W+1)'(LINE_TICKS)) begin
                    err_h_now = 1'b1;
                end
            end
            if (hs_rise && hc_inc != (CNT_W+1)'(HSYNC_TICKS)) begin
                err_h_now = 1'b1;
            end

            if (vs_fall) begin
                vc_next = '0;
                if (state != SEARCH && vc_inc != (CNT_W+1)'(FRAME_LINES)) begin
                    err_v_now = 1'b1;
                end
            end else if (hs_fall) begin
                vc_next = sat_inc(vc);
                if (vc_inc == (CNT_W+1)'(FRAME_LINES)) begin
                    err_v_now = 1'b1;
                end
            end
            // The generator raises vsync on the same tick that hsync falls
            // into line VSYNC_LINES, so the check uses the updated line count.
            if (vs_rise && vc_next != CNT_W'(VSYNC_LINES)) begin
                err_v_now = 1'b1;
            end
        end
    end

    assign err_any = err_h_now | err_v_now;

    // clean tracks whether the frame in progress has been free of errors.
    // An error on the vsync-fall tick belongs to the frame that is ending,
    // so the new frame still starts clean.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        clean_next = clean;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_next = MEASURE;
                    good_next  = '0;
                    clean_next = 1'b1;
                end
            end
            MEASURE: begin
                if (err_any) begin
                    good_next = '0;
                end else if (vs_fall && clean) begin
                    good_next = good_cnt + 4'd1;
                    if ({1'b0, good_cnt} + 5'd1 >= 5'(LOCK_FRAMES)) begin
                        state_next = LOCKED;
                    end
                end
                if (vs_fall) begin
                    clean_next = 1'b1;
                end else if (err_any) begin
                    clean_next = 1'b0;
                end
            end
            LOCKED: begin
                if (err_any) begin
                    state_next = MEASURE;
                    good_next  = '0;
                    clean_next = vs_fall;
                end
            end
            default: begin
                state_next = SEARCH;
                good_next  = '0;
                clean_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        locked_next = (state_next == LOCKED);
        in_window   = (hc_next >= CNT_W'(HACT_START))
                   && (hc_next <  CNT_W'(HACT_START + HACT_TICKS))
                   && (vc_next >= CNT_W'(VACT_START))
                   && (vc_next <  CNT_W'(VACT_START + VACT_LINES));
        active_next = locked_next & in_window;
        x_next      = '0;
        y_next      = '0;
        if (active_next) begin
            x_next = hc_next - CNT_W'(HACT_START);
            y_next = vc_next - CNT_W'(VACT_START);
        end
    end

    // The next-state values equal the current values on non-tick cycles, so
    // every register can load each clk. The pulse outputs are set only by a
    // pixel tick, and they clear on the following clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            hc          <= '0;
            vc          <= '0;
            good_cnt    <= '0;
            clean       <= 1'b0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            err_h       <= 1'b0;
            err_v       <= 1'b0;
        end else begin
            state       <= state_next;
            hc          <= hc_next;
            vc          <= vc_next;
            good_cnt    <= good_next;
            clean       <= clean_next;
            x           <= x_next;
            y           <= y_next;
            active      <= active_next;
            locked      <= locked_next;
            frame_start <= vs_fall;
            err_h       <= err_h_now;
            err_v       <= err_v_now;
        end
    end

`ifdef VGA_MON_BRIGHT_CHECK_EN
    // The upstream bright is registered, so it lags the window by one tick.
    // The registered active and locked flags give that same one-tick delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_bright <= 1'b0;
        end else if (pix_en && locked && (bright != active)) begin
            err_bright <= 1'b1;
        end
    end
`else
    logic unused_bright;
    assign unused_bright = bright;
    assign err_bright    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor
//   Bench for vga_timing_monitor, built with a reduced raster so that full
//   frames stay short. A generator produces sync and bright per pixel tick and
//   injects timing faults. A reference model re-derives the expected outputs
//   from the line/frame rules for every pixel tick and for every idle clk
//   between ticks. Directed checks are also made at lock, window-boundary and
//   fault points.
module tb_vga_timing_monitor;

    localparam int LT   = 32;   // ticks per line
    localparam int HS   = 4;    // hsync low ticks
    localparam int HAS  = 8;    // first active tick
    localparam int HAT  = 20;   // active ticks
    localparam int FL   = 16;   // lines per frame
    localparam int VS   = 2;    // vsync low lines
    localparam int VAS  = 4;    // first active line
    localparam int VAL  = 10;   // active lines
    localparam int LOCK = 2;

    logic       clk = 1'b0;
    logic       rst_n, pix_en, hsync, vsync, bright;
    logic [9:0] x, y;
    logic       active, locked, frame_start, err_h, err_v, err_bright;

    always #5 clk = ~clk;

    vga_timing_monitor #(
        .LINE_TICKS (LT),  .HSYNC_TICKS (HS),  .HACT_START (HAS), .HACT_TICKS (HAT),
        .FRAME_LINES(FL),  .VSYNC_LINES (VS),  .VACT_START (VAS), .VACT_LINES (VAL),
        .LOCK_FRAMES(LOCK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .bright(bright), .x(x), .y(y), .active(active), .locked(locked),
        .frame_start(frame_start), .err_h(err_h), .err_v(err_v), .err_bright(err_bright)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: ticks since hsync fall, lines since vsync fall,
    // acquisition mode (0 searching, 1 measuring, 2 locked).
    int m_hc, m_vc, m_mode, m_good, e_x, e_y;
    bit m_phs, m_pvs, m_clean, m_eb, e_act, e_lock, e_fs, e_eh, e_ev;

    // Generator configuration / fault injection
    bit g_prev_win = 1'b0;
    int short_v  = -1;
    int narrow_v = -1;
    bit no_vs    = 1'b0;
    int kill_h   = -1;
    int kill_v   = -1;
    bit dir_on   = 1'b0;
    int cnt_ev   = 0;
    int cnt_fs   = 0;

    function automatic logic [25:0] obs();
        return {x, y, active, locked, frame_start, err_h, err_v, err_bright};
    endfunction

    function automatic logic [25:0] exp_vec(input bit pulses);
        return {10'(e_x), 10'(e_y), e_act, e_lock,
                pulses & e_fs, pulses & e_eh, pulses & e_ev, m_eb};
    endfunction

    task automatic check(input string tag, input logic [25:0] o, input logic [25:0] e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_hc = 0; m_vc = 0; m_mode = 0; m_good = 0;
        m_phs = 1'b1; m_pvs = 1'b1; m_clean = 1'b0; m_eb = 1'b0;
        e_x = 0; e_y = 0; e_act = 1'b0; e_lock = 1'b0;
        e_fs = 1'b0; e_eh = 1'b0; e_ev = 1'b0;
    endtask

    task automatic model_step(input bit hs, input bit vs, input bit br);
        bit hf, hr, vf, vr, eh, ev, err, win;
        int ohc, ovc;
        hf = m_phs && !hs;  hr = !m_phs && hs;
        vf = m_pvs && !vs;  vr = !m_pvs && vs;
        m_phs = hs; m_pvs = vs;
        ohc = m_hc; ovc = m_vc;
        eh = 1'b0; ev = 1'b0;
        if (hf) begin
            eh   = (m_mode != 0) && (ohc + 1 != LT);
            m_hc = 0;
        end else begin
            eh   = (ohc + 1 == LT);
            m_hc = (ohc + 1 > 1023) ? 1023 : ohc + 1;
        end
        if (hr && (ohc + 1 != HS)) eh = 1'b1;
        if (vf) begin
            ev   = (m_mode != 0) && (ovc + 1 != FL);
            m_vc = 0;
        end else if (hf) begin
            ev   = (ovc + 1 == FL);
            m_vc = (ovc + 1 > 1023) ? 1023 : ovc + 1;
        end
        if (vr && (m_vc != VS)) ev = 1'b1;
        err = eh || ev;
        if (m_mode == 0) begin
            if (vf) begin m_mode = 1; m_good = 0; m_clean = 1'b1; end
        end else begin
            if (err) begin
                m_good = 0;
                m_mode = 1;
            end else if (vf && m_clean && m_mode == 1) begin
                m_good++;
                if (m_good >= LOCK) m_mode = 2;
            end
            if (vf) m_clean = 1'b1;
            else if (err) m_clean = 1'b0;
        end
`ifdef VGA_MON_BRIGHT_CHECK_EN
        if (e_lock && (br != e_act)) m_eb = 1'b1;
`else
        if (br) m_eb = m_eb;
`endif
        e_fs = vf; e_eh = eh; e_ev = ev;
        e_lock = (m_mode == 2);
        win = (m_hc >= HAS) && (m_hc < HAS + HAT) && (m_vc >= VAS) && (m_vc < VAS + VAL);
        e_act = e_lock && win;
        e_x = e_act ? m_hc - HAS : 0;
        e_y = e_act ? m_vc - VAS : 0;
    endtask

    task automatic tick(input bit hs, input bit vs, input bit br);
        @(negedge clk);
        check("hold", obs(), exp_vec(1'b0));
        hsync = hs; vsync = vs; bright = br; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        model_step(hs, vs, br);
        check("tick", obs(), exp_vec(1'b1));
        cnt_ev += int'(err_v);
        cnt_fs += int'(frame_start);
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic send_line(input int v);
        int len, hsw;
        bit br;
        len = (v == short_v)  ? LT - 1 : LT;
        hsw = (v == narrow_v) ? HS - 1 : HS;
        for (int h = 0; h < len; h++) begin
            br = g_prev_win;
            if (v == kill_v && h == kill_h) br = 1'b0;
            g_prev_win = (h >= HAS) && (h < HAS + HAT) && (v >= VAS) && (v < VAS + VAL);
            tick((h < hsw) ? 1'b0 : 1'b1, (!no_vs && v < VS) ? 1'b0 : 1'b1, br);
            if (short_v >= 0 && v == short_v + 1 && h == 0)
                check("short_line", 26'({locked, err_h}), 26'b01);
            if (v == narrow_v && h == HS - 1)
                check("narrow_sync", 26'({locked, err_h}), 26'b01);
            if (dir_on) begin
                if (h == 0 && v == 0)
                    check("lock_rise", 26'({locked, frame_start}), 26'b11);
                if (h == HAS && v == VAS)
                    check("first_px", 26'({active, x, y}), {1'b1, 10'd0, 10'd0});
                if (h == HAS + HAT && v == VAS)
                    check("h_blank", 26'({active, x, y}), 26'd0);
                if (h == HAS + HAT - 1 && v == VAS + VAL - 1)
                    check("last_px", 26'({active, x, y}), {1'b1, 10'(HAT - 1), 10'(VAL - 1)});
            end
        end
    endtask

    task automatic send_frame(input int first, input int last);
        for (int v = first; v <= last; v++) send_line(v);
    endtask

    initial begin
        int rl;
        rst_n = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; bright = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", obs(), 26'd0);
        rst_n = 1'b1;

        // Random idle pre-roll, then three nominal frames.
        repeat ($urandom_range(0, 40)) tick(1'b1, 1'b1, 1'b0);
        send_frame(0, FL - 1);
        send_frame(0, FL - 1);
        check("lock_early", 26'(locked), 26'd0);
        dir_on = 1'b1;
        send_frame(0, FL - 1);
        dir_on = 1'b0;

        // One short line while locked, then reacquire.
        short_v = $urandom_range(2, FL - 2);
        send_frame(0, FL - 1);
        short_v = -1;
        check("unlock_short", 26'(locked), 26'd0);
        send_frame(0, FL - 1);
        send_frame(0, FL - 1);
        check("relock_early", 26'(locked), 26'd0);
        send_frame(0, FL - 1);
        check("relock", 26'(locked), 26'd1);

        // Narrow hsync pulse on one line.
        narrow_v = $urandom_range(3, FL - 1);
        send_frame(0, FL - 1);
        narrow_v = -1;
        check("unlock_narrow", 26'(locked), 26'd0);
        send_frame(0, FL - 1);
        send_frame(0, FL - 1);
        send_frame(0, FL - 1);
        check("relock2", 26'(locked), 26'd1);

        // A frame without a vsync pulse: one timeout and no frame_start.
        cnt_ev = 0; cnt_fs = 0;
        no_vs = 1'b1;
        send_frame(0, FL - 1);
        no_vs = 1'b0;
        check("vtimeout_count", 26'(cnt_ev), 26'd1);
        check("no_frame_start", 26'(cnt_fs), 26'd0);

        // Relock, then assert reset partway through a frame.
        send_frame(0, FL - 1);
        send_frame(0, FL - 1);
        rl = $urandom_range(3, 8);
        send_frame(0, rl);
        check("locked_pre_rst", 26'(locked), 26'd1);
        #2 rst_n = 1'b0;
        #1 check("async_rst", obs(), 26'd0);
        repeat (3) @(negedge clk);
        check("rst_hold", obs(), 26'd0);
        rst_n = 1'b1;
        model_reset();
        send_frame(rl + 1, FL - 1);
        send_frame(0, FL - 1);
        send_frame(0, FL - 1);
        check("reacq_early", 26'(locked), 26'd0);
        kill_h = $urandom_range(HAS + 1, HAS + HAT - 1);
        kill_v = $urandom_range(VAS, VAS + VAL - 1);
        send_frame(0, FL - 1);
        check("reacq", 26'(locked), 26'd1);
`ifdef VGA_MON_BRIGHT_CHECK_EN
        check("err_bright", 26'(err_bright), 26'd1);
`else
        check("err_bright", 26'(err_bright), 26'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
